// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_pkg
//  Description : Shared definitions for the UART command sequencer: header
//                field indices, the error response byte and the FSM state
//                encoding. Header states reuse the field index as their code.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

  // Position of each byte within the 4-byte command header.
  localparam logic [2:0] HDR_OPCODE   = 3'd0;
  localparam logic [2:0] HDR_RESERVED = 3'd1;
  localparam logic [2:0] HDR_LEN_LSB  = 3'd2;
  localparam logic [2:0] HDR_LEN_MSB  = 3'd3;

  // Single byte returned for an unknown opcode or a unit timeout.
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    StOpcode   = HDR_OPCODE,
    StReserved = HDR_RESERVED,
    StLenLsb   = HDR_LEN_LSB,
    StLenMsb   = HDR_LEN_MSB,
    StStart    = 3'd4,
    StWait     = 3'd5,
    StTx       = 3'd6,
    StErr      = 3'd7
  } state_e;

  // True while the FSM is collecting header bytes (byte sink open).
  function automatic logic is_header(input state_e s);
    return (s == StOpcode) || (s == StReserved) ||
           (s == StLenLsb) || (s == StLenMsb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_seq_if
//  Description : Byte-stream bundle of the UART command sequencer.
//                rx_* : valid/ready byte sink into the sequencer
//                tx_* : valid/ready byte source out of the sequencer
//                Signal suffixes are from the sequencer's point of view; the
//                sequencer uses modport slave, the UART side modport master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_seq_if #(
  parameter int datawidth_p = 8
) ();

  logic [datawidth_p-1:0] rx_data_i;
  logic                   rx_valid_i;
  logic                   rx_ready_o;
  logic [datawidth_p-1:0] tx_data_o;
  logic                   tx_valid_o;
  logic                   tx_ready_i;

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/uart_byte_ser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_ser
//  Description : MSB-first byte serialiser with a valid/ready output.
//                load_i        : capture load_data_i and send load_nbytes_i
//                                bytes starting from the top byte
//                data_o/valid_o: registered byte stream, held while stalled
//                ready_i       : downstream ready
//                last_o        : final byte completes this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_ser #(
  parameter int datawidth_p    = 8,
  parameter int result_bytes_p = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              load_i,
  input  logic [8*result_bytes_p-1:0]       load_data_i,
  input  logic [$clog2(result_bytes_p+1)-1:0] load_nbytes_i,
  output logic [datawidth_p-1:0]            data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              last_o
);

  localparam int RW  = 8 * result_bytes_p;
  localparam int NBW = $clog2(result_bytes_p + 1);

  // The shift register doubles as the result holding register, so the
  // source word may change freely once loaded.
  logic [RW-1:0]  shift_q, shift_d;
  logic [NBW-1:0] left_q,  left_d;
  logic           valid_q, valid_d;
  logic           fire;

  assign fire = valid_q & ready_i;

  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = load_data_i;
      left_d  = load_nbytes_i;
      valid_d = (load_nbytes_i != '0);
    end else if (fire) begin
      if (left_q == NBW'(1)) begin
        shift_d = '0;
        left_d  = '0;
        valid_d = 1'b0;
      end else begin
        shift_d = shift_q << 8;
        left_d  = left_q - NBW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = datawidth_p'(shift_q[RW-1 -: 8]);
  assign valid_o = valid_q;
  assign last_o  = fire && (left_q == NBW'(1));

endmodule
`default_nettype wire

// File: rtl/uart_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_seq
//  Description : UART command sequencer. Receives a 4-byte header
//                (opcode, reserved, len LSB, len MSB), starts the compute
//                unit selected by the opcode, waits for its done, and returns
//                its result MSB-first. Unknown opcodes and timeouts answer
//                with the single byte 8'hEE and an err_o pulse.
//                clk_i/rst_i : clock, synchronous active-high reset
//                bus         : rx byte sink / tx byte source (slave modport)
//                start_o     : one-hot, one-cycle unit start
//                done_i      : per-unit done
//                result_i    : unit k result at [k*rw +: rw]
//                len_o       : latched command length
//                err_o       : one-cycle pulse per error response
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_seq
  import uart_alu_pkg::*;
#(
  parameter int datawidth_p    = 8,
  parameter int num_units_p    = 4,
  parameter int result_bytes_p = 4,
  parameter int opcode_base_p  = 8'h10,
  parameter int timeout_p      = 2**20
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  uart_cmd_seq_if.slave                         bus,
  output logic [num_units_p-1:0]                start_o,
  input  logic [num_units_p-1:0]                done_i,
  input  logic [num_units_p*8*result_bytes_p-1:0] result_i,
  output logic [15:0]                           len_o,
  output logic                                  err_o
);

  localparam int RW  = 8 * result_bytes_p;
  localparam int UW  = (num_units_p > 1) ? $clog2(num_units_p) : 1;
  localparam int NBW = $clog2(result_bytes_p + 1);
  localparam int TW  = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam bit TOUT_EN = (timeout_p != 0);
  localparam logic [TW-1:0] TOUT_MAX = TW'((timeout_p > 0) ? timeout_p - 1 : 0);

  state_e                 state_q;
  logic [7:0]             opcode_q;
  logic [7:0]             len_lsb_q;
  logic [15:0]            len_q;
  logic [UW-1:0]          unit_q;
  logic [num_units_p-1:0] start_q;
  logic                   err_q;
  logic [TW-1:0]          tout_q;

  logic [7:0]             rx_byte;
  logic                   rx_ready;
  logic                   rx_fire;
  logic                   unit_hit;
  logic [UW-1:0]          unit_idx;
  logic [num_units_p-1:0] unit_onehot;
  logic                   unit_done;
  logic                   tout_hit;
  logic [RW-1:0]          err_word;
  logic [RW-1:0]          res_word;
  logic                   load_result;
  logic                   load_err;
  logic                   ser_load;
  logic [RW-1:0]          ser_word;
  logic [NBW-1:0]         ser_nbytes;
  logic                   ser_last;

  // Sink is held closed while reset is asserted so no byte is claimed.
  assign rx_ready       = !rst_i && is_header(state_q);
  assign bus.rx_ready_o = rx_ready;
  assign rx_byte        = bus.rx_data_i[7:0];
  assign rx_fire        = bus.rx_valid_i && rx_ready;

  // Opcode decode: a unit exists for base <= opcode < base + num_units.
  assign unit_hit = (32'(opcode_q) >= 32'(opcode_base_p)) &&
                    (32'(opcode_q) <  32'(opcode_base_p) + 32'(num_units_p));
  assign unit_idx = UW'(32'(opcode_q) - 32'(opcode_base_p));

  always_comb begin
    unit_onehot = '0;
    for (int k = 0; k < num_units_p; k++) begin
      if (k == int'(unit_idx)) unit_onehot[k] = 1'b1;
    end
  end

  assign unit_done = done_i[unit_q];
  assign tout_hit  = TOUT_EN && (tout_q == TOUT_MAX);
  assign res_word  = result_i[int'(unit_q)*RW +: RW];

  always_comb begin
    err_word = '0;
    err_word[RW-1 -: 8] = ERR_BYTE;
  end

  // The serialiser is loaded on the same edge the FSM enters StTx/StErr,
  // so tx_valid_o rises on the first cycle of those states.
  assign load_result = (state_q == StWait) && unit_done;
  assign load_err    = ((state_q == StWait) && !unit_done && tout_hit) ||
                       ((state_q == StLenMsb) && rx_fire && !unit_hit);
  assign ser_load    = load_result || load_err;
  assign ser_word    = load_result ? res_word : err_word;
  assign ser_nbytes  = load_result ? NBW'(result_bytes_p) : NBW'(1);

  uart_byte_ser #(
    .datawidth_p    (datawidth_p),
    .result_bytes_p (result_bytes_p)
  ) u_ser (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (ser_load),
    .load_data_i   (ser_word),
    .load_nbytes_i (ser_nbytes),
    .data_o        (bus.tx_data_o),
    .valid_o       (bus.tx_valid_o),
    .ready_i       (bus.tx_ready_i),
    .last_o        (ser_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StOpcode;
      opcode_q  <= '0;
      len_lsb_q <= '0;
      len_q     <= '0;
      unit_q    <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
      tout_q    <= '0;
    end else begin
      start_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        StOpcode: begin
          if (rx_fire) begin
            opcode_q <= rx_byte;
            state_q  <= StReserved;
          end
        end
        StReserved: begin
          if (rx_fire) state_q <= StLenLsb;
        end
        StLenLsb: begin
          if (rx_fire) begin
            len_lsb_q <= rx_byte;
            state_q   <= StLenMsb;
          end
        end
        StLenMsb: begin
          if (rx_fire) begin
            len_q <= {rx_byte, len_lsb_q};
            if (unit_hit) begin
              unit_q  <= unit_idx;
              start_q <= unit_onehot;
              state_q <= StStart;
            end else begin
              state_q <= StErr;
            end
          end
        end
        StStart: begin
          // done_i is not looked at here; sampling begins in StWait.
          tout_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (unit_done) begin
            state_q <= StTx;
          end else if (tout_hit) begin
            state_q <= StErr;
          end else begin
            tout_q <= tout_q + TW'(1);
          end
        end
        StTx: begin
          if (ser_last) state_q <= StOpcode;
        end
        StErr: begin
          if (ser_last) begin
            err_q   <= 1'b1;
            state_q <= StOpcode;
          end
        end
        default: state_q <= StOpcode;
      endcase
    end
  end

  assign start_o = start_q;
  assign len_o   = len_q;
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_seq
//  Description : Directed self-checking bench for uart_cmd_seq: valid
//                commands, unknown opcode, timeout, tx back-pressure and
//                reset in the middle of a response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   start;
  logic [3:0]   done;
  logic [127:0] result;
  logic [15:0]  len;
  logic         err;

  always #5 clk = ~clk;

  uart_cmd_seq_if #(.datawidth_p(8)) bus ();

  uart_cmd_seq #(
    .datawidth_p    (8),
    .num_units_p    (4),
    .result_bytes_p (4),
    .opcode_base_p  (8'h10),
    .timeout_p      (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .start_o  (start),
    .done_i   (done),
    .result_i (result),
    .len_o    (len),
    .err_o    (err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int         cyc = 0;
  logic [7:0] tx_q[$];
  int         start_cnt[4];
  int         err_cnt;
  int         start_cyc;
  int         first_txv_cyc;
  logic       prev_stall = 1'b0;
  logic       prev_txv   = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_data_o);
      if (bus.tx_valid_o && !prev_txv && first_txv_cyc < 0) first_txv_cyc = cyc;
      for (int k = 0; k < 4; k++) begin
        if (start[k]) begin
          start_cnt[k]++;
          start_cyc = cyc;
        end
      end
      if (err) err_cnt++;
      if (prev_stall) check("stall_hold", {bus.tx_valid_o, bus.tx_data_o}, {1'b1, prev_data});
    end
    prev_stall = bus.tx_valid_o && !bus.tx_ready_i && !rst;
    prev_txv   = bus.tx_valid_o;
    prev_data  = bus.tx_data_o;
  end

  task automatic clear_mon();
    tx_q.delete();
    for (int k = 0; k < 4; k++) start_cnt[k] = 0;
    err_cnt       = 0;
    start_cyc     = 0;
    first_txv_cyc = -1;
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] hdr[4];
    int k;
    hdr = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) begin
      bus.rx_data_i  = hdr[i];
      bus.rx_valid_i = 1'b1;
      k = 0;
      while (!bus.rx_ready_o && k < 50) begin
        tick();
        k++;
      end
      check("rx_accept", 64'(k < 50), 64'd1);
      tick();
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    step();
    while (!(tx_q.size() >= n && !bus.tx_valid_o) && k < 300) begin
      step();
      k++;
    end
    check("tx_wait", 64'(k < 300), 64'd1);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    check({tag, "_count"}, 64'(tx_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check({tag, "_byte"}, 64'(b), 64'(w[31-8*i -: 8]));
    end
  endtask

  function automatic int start_total();
    return start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst            = 1'b1;
    done           = '0;
    result         = '0;
    bus.rx_data_i  = '0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    clear_mon();

    // Reset state
    repeat (3) tick();
    step();
    check("rst_tx_valid", 64'(bus.tx_valid_o), 64'd0);
    check("rst_start",    64'(start), 64'd0);
    check("rst_err",      64'(err), 64'd0);
    check("rst_len",      64'(len), 64'd0);
    check("rst_rx_ready", 64'(bus.rx_ready_o), 64'd0);
    tick();
    rst = 1'b0;
    step();
    check("rel_rx_ready", 64'(bus.rx_ready_o), 64'd1);

    // Unit 0, result DEADBEEF; result changes after capture
    tick();
    clear_mon();
    send_cmd(8'h10, 8'h00, 8'h04, 8'h00);
    repeat (3) tick();
    result[31:0] = 32'hDEADBEEF;
    done = 4'b0001;
    tick();
    done = 4'b0000;
    result[31:0] = 32'h12345678;
    wait_tx(4);
    tick();
    check("t1_start0", 64'(start_cnt[0]), 64'd1);
    check("t1_start_all", 64'(start_total()), 64'd1);
    check("t1_len", 64'(len), 64'h0004);
    check_word("t1", 32'hDEADBEEF);
    check("t1_err", 64'(err_cnt), 64'd0);
    check("t1_rx_ready", 64'(bus.rx_ready_o), 64'd1);

    // Unit 3: done during start cycle and done of another unit are ignored
    clear_mon();
    send_cmd(8'h13, 8'h00, 8'h01, 8'h00);
    result[127:96] = 32'hBADBAD00;
    done = 4'b1000;
    tick();
    done = 4'b0001;
    result[31:0] = 32'hFFFFFFFF;
    tick();
    done = 4'b0000;
    result[127:96] = 32'h00000001;
    tick();
    done = 4'b1000;
    tick();
    done = 4'b0000;
    result[127:96] = 32'hFFFFFFFF;
    wait_tx(4);
    tick();
    check("t2_start3", 64'(start_cnt[3]), 64'd1);
    check("t2_start_all", 64'(start_total()), 64'd1);
    check("t2_len", 64'(len), 64'h0001);
    check_word("t2", 32'h00000001);
    check("t2_err", 64'(err_cnt), 64'd0);

    // Unknown opcode, len 0
    clear_mon();
    send_cmd(8'h2A, 8'h00, 8'h00, 8'h00);
    wait_tx(1);
    tick();
    check("t3_no_start", 64'(start_total()), 64'd0);
    check("t3_count", 64'(tx_q.size()), 64'd1);
    check("t3_byte", 64'(tx_q.size() > 0 ? tx_q[0] : 8'hxx), 64'hEE);
    check("t3_err", 64'(err_cnt), 64'd1);
    check("t3_len", 64'(len), 64'h0000);
    check("t3_rx_ready", 64'(bus.rx_ready_o), 64'd1);

    // Unit 1 never finishes: timeout after 16 StWait cycles
    clear_mon();
    send_cmd(8'h11, 8'h00, 8'h02, 8'h00);
    wait_tx(1);
    tick();
    check("t4_start1", 64'(start_cnt[1]), 64'd1);
    check("t4_count", 64'(tx_q.size()), 64'd1);
    check("t4_byte", 64'(tx_q.size() > 0 ? tx_q[0] : 8'hxx), 64'hEE);
    check("t4_err", 64'(err_cnt), 64'd1);
    check("t4_latency", 64'(first_txv_cyc - (start_cyc + 1)), 64'd16);
    check("t4_len", 64'(len), 64'h0002);

    // Unit 2 with random tx back-pressure
    clear_mon();
    send_cmd(8'h12, 8'h00, 8'h05, 8'h00);
    tick();
    bus.tx_ready_i = 1'b0;
    result[95:64] = 32'hCAFEF00D;
    done = 4'b0100;
    tick();
    done = 4'b0000;
    begin
      int k;
      k = 0;
      while (!(tx_q.size() >= 4 && !bus.tx_valid_o) && k < 300) begin
        bus.tx_ready_i = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      check("t5_wait", 64'(k < 300), 64'd1);
    end
    bus.tx_ready_i = 1'b1;
    tick();
    check("t5_start2", 64'(start_cnt[2]), 64'd1);
    check("t5_len", 64'(len), 64'h0005);
    check_word("t5", 32'hCAFEF00D);

    // Reset after the second result byte
    clear_mon();
    send_cmd(8'h10, 8'h00, 8'h03, 8'h00);
    tick();
    result[31:0] = 32'h11223344;
    done = 4'b0001;
    tick();
    done = 4'b0000;
    begin
      int k;
      k = 0;
      while (tx_q.size() < 2 && k < 100) begin
        step();
        k++;
      end
      check("t6_wait", 64'(k < 100), 64'd1);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    step();
    check("t6_tx_valid", 64'(bus.tx_valid_o), 64'd0);
    check("t6_rx_ready", 64'(bus.rx_ready_o), 64'd1);
    check("t6_len", 64'(len), 64'h0000);
    repeat (5) tick();
    check("t6_count", 64'(tx_q.size()), 64'd2);
    check("t6_b0", 64'(tx_q.size() > 0 ? tx_q[0] : 8'hxx), 64'h11);
    check("t6_b1", 64'(tx_q.size() > 1 ? tx_q[1] : 8'hxx), 64'h22);

    // New command completes normally after the reset
    clear_mon();
    send_cmd(8'h13, 8'h00, 8'h07, 8'h00);
    tick();
    result[127:96] = 32'h0A0B0C0D;
    done = 4'b1000;
    tick();
    done = 4'b0000;
    wait_tx(4);
    tick();
    check("t7_start3", 64'(start_cnt[3]), 64'd1);
    check("t7_len", 64'(len), 64'h0007);
    check_word("t7", 32'h0A0B0C0D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_seq.md
UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

Interface
REQ-001 The block SHALL have parameter datawidth_p, default 8, meaning the UART byte width.
REQ-002 The block SHALL have parameter num_units_p, default 4, meaning the number of attached compute units (1..16).
REQ-003 The block SHALL have parameter result_bytes_p, default 4, meaning the bytes per result (1..8); result width rw = 8*result_bytes_p.
REQ-004 The block SHALL have parameter opcode_base_p, default 8'h10, meaning the opcode of unit 0; unit k uses opcode_base_p+k.
REQ-005 The block SHALL have parameter timeout_p, default 2**20, meaning the maximum cycles to wait for done (0 disables the timeout).
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, a synchronous, active-high reset.
REQ-008 The block SHALL have ports rx_data_i (input, datawidth_p), rx_valid_i (input, 1) and rx_ready_o (output, 1), forming the valid/ready byte sink.
REQ-009 The block SHALL have ports tx_data_o (output, datawidth_p), tx_valid_o (output, 1) and tx_ready_i (input, 1), forming the valid/ready byte source.
REQ-010 The block SHALL have ports start_o (output, num_units_p, one-hot pulse) and done_i (input, num_units_p, per-unit done).
REQ-011 The block SHALL have port result_i, input, num_units_p*rw bits, with unit k at bits [k*rw +: rw].
REQ-012 The block SHALL have ports len_o (output, 16, command length) and err_o (output, 1, one-cycle pulse per error response sent).

Function
REQ-013 The FSM SHALL have exactly these states: StOpcode, StReserved, StLenLsb, StLenMsb, StStart, StWait, StTx and StErr.
REQ-014 rx_ready_o SHALL be 1 only in StOpcode, StReserved, StLenLsb and StLenMsb; a byte is accepted only on a cycle where rx_valid_i and rx_ready_o are both 1.
REQ-015 On an accept, the FSM SHALL advance StOpcode->StReserved->StLenLsb->StLenMsb, latching the opcode byte in StOpcode and the reserved byte in StReserved, which is then discarded.
REQ-016 In StLenLsb the accepted byte SHALL become len[7:0], and in StLenMsb it SHALL become len[15:8]; len_o holds the latched value until the next command's StLenMsb accept.
REQ-017 On the StLenMsb accept, if opcode-opcode_base_p lies in [0, num_units_p), the FSM SHALL go to StStart; otherwise it SHALL go to StErr, and no start_o is raised.
REQ-018 StStart SHALL last exactly one cycle, during which start_o[unit] = 1 and all other start_o bits are 0; the FSM then enters StWait.
REQ-019 In StWait, done_i[unit] = 1 SHALL capture result_i for that unit into a holding register and go to StTx; done_i bits of other units are ignored.
REQ-020 done_i[unit] asserted in the same cycle as start_o SHALL be ignored; it is sampled only from the first StWait cycle onward.
REQ-021 The timeout counter SHALL clear on entry to StWait; if it reaches timeout_p-1 without done (timeout_p != 0), the FSM SHALL go to StErr.
REQ-022 StTx SHALL send result_bytes_p bytes MSB-first, with tx_valid_o registered and first asserted the cycle after StWait exits.
REQ-023 tx_data_o and tx_valid_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0; a byte completes on the cycle tx_valid_o and tx_ready_i are both 1.
REQ-024 On completion of the last byte in StTx, tx_valid_o SHALL drop the next cycle and the FSM SHALL return to StOpcode.
REQ-025 In StErr the block SHALL send the single byte 8'hEE with the same handshake, pulse err_o for one cycle on its completion, and then return to StOpcode.
REQ-026 Changes on result_i after capture SHALL NOT affect transmitted bytes.
REQ-027 len = 0 SHALL be legal, passed through unchanged, and SHALL NOT be treated as an error.

Reset
REQ-028 When rst_i=1 at a clock edge, the FSM SHALL enter StOpcode and all outputs, counters and holding registers SHALL reset to 0; reset takes effect in every state, mid-command included.
REQ-029 On the first cycle after reset release, rx_ready_o SHALL be 1, and any partial command, transmission or timeout SHALL be abandoned with no trailing byte.

Structure
REQ-030 Package uart_alu_pkg SHALL hold the state enum, the ERR_BYTE constant 8'hEE and the header field indices.
REQ-031 The MSB-first byte serialiser SHALL be a sub-module named uart_byte_ser, parametrised by datawidth_p and result_bytes_p, with a load strobe plus a valid/ready output; the top instance is used for both result and error bytes.

Verification
REQ-032 The bench SHALL send 10 00 04 00 with rx_valid held high, and check one start_o[0] pulse, len_o=16'h0004, and that done_i[0] with result 32'hDEADBEEF yields DE AD BE EF.
REQ-033 The bench SHALL send 13 00 01 00, and check one start_o[3] pulse and that done_i[3] with result 32'h00000001 yields 00 00 00 01.
REQ-034 The bench SHALL send 2A 00 00 00, and check that no start_o occurs, tx sends EE, err_o pulses once, and the FSM returns to StOpcode.
REQ-035 The bench SHALL set timeout_p=16, send 11 00 02 00 and never raise done, and check that EE is sent exactly 16 cycles after entry to StWait.
REQ-036 The bench SHALL toggle tx_ready_i randomly during a 4-byte result, and check that no byte is dropped or duplicated and tx_data_o is stable while stalled.
REQ-037 The bench SHALL assert rst_i after the 2nd result byte is accepted, and check that tx_valid_o=0 and rx_ready_o=1 the cycle after release, and that a new command then completes normally.
